// File: rtl/fir_pkg.sv
// Shared constants, state encoding and arithmetic helpers
// for the time-multiplexed FIR engine.
package fir_pkg;

  localparam int TAPS_D      = 8;
  localparam int DW_D        = 8;
  localparam int CW_D        = 8;
  localparam int OUT_SHIFT_D = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  // Floor shift, then clamp into a signed field of the given width.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] value,
    input int                 shift,
    input int                 width
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = value >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) begin
      return hi;
    end
    if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate; clear wins over enable.
// o_sum exposes the value the next enabled edge will store.
module fir_mac_unit #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int ACCW = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic signed [DW-1:0]   i_x,
  input  logic signed [CW-1:0]   i_c,
  output logic signed [ACCW-1:0] o_sum
);

  logic signed [DW+CW-1:0] w_prod;
  logic signed [ACCW-1:0]  w_prod_ext;
  logic signed [ACCW-1:0]  r_acc;

  assign w_prod     = i_x * i_c;
  assign w_prod_ext = {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
  assign o_sum      = r_acc + w_prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR controller: sample delay line, coefficient file and a
// single shared MAC stepped across all taps per sample.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int TAPS      = TAPS_D,
  parameter int DW        = DW_D,
  parameter int CW        = CW_D,
  parameter int ACCW      = acc_width(DW, CW, TAPS),
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DW-1:0]     in_data,
  input  logic                     flush,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [CW-1:0]     coef_data,
  output logic                     coef_ready,
  output logic                     busy,
  output logic                     out_valid,
  output logic signed [ACCW-1:0]   out_full,
  output logic signed [DW-1:0]     out_sat
);

  localparam int AW = $clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  fir_state_t             r_state;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_k;
  logic signed [DW-1:0]   r_delay [TAPS];
  logic signed [CW-1:0]   r_coef  [TAPS];
  logic                   r_out_valid;
  logic signed [ACCW-1:0] r_out_full;
  logic signed [DW-1:0]   r_out_sat;

  logic                   w_idle;
  logic                   w_accept;
  logic                   w_coef_wr;
  logic                   w_flush;
  logic                   w_mac;
  logic                   w_last;
  logic [AW-1:0]          w_rd_idx;
  logic signed [ACCW-1:0] w_sum;
  logic signed [63:0]     w_sum_ext;
  logic signed [DW-1:0]   w_sat;

  assign w_idle     = (r_state == IDLE);
  assign in_ready   = w_idle & ~flush;
  assign coef_ready = w_idle;
  assign busy       = ~w_idle;

  assign w_accept  = in_valid & in_ready;
  assign w_coef_wr = coef_we & coef_ready;
  assign w_flush   = flush & w_idle;
  assign w_mac     = (r_state == MAC);
  assign w_last    = w_mac & (r_k == LAST);

  // Newest sample pairs with tap 0; older ones walk backwards.
  assign w_rd_idx  = r_wr_ptr - r_k;

  assign w_sum_ext = {{(64-ACCW){w_sum[ACCW-1]}}, w_sum};
  assign w_sat     = DW'(sat_shift(w_sum_ext, OUT_SHIFT, DW));

  fir_mac_unit #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (w_mac),
    .i_x   (r_delay[w_rd_idx]),
    .i_c   (r_coef[r_k]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_k      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= MAC;
            r_k     <= '0;
          end
        end
        MAC: begin
          r_k <= r_k + AW'(1);
          if (w_last) begin
            r_state  <= DONE;
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_delay[i] <= '0;
        r_coef[i]  <= '0;
      end
    end else begin
      if (w_flush) begin
        for (int i = 0; i < TAPS; i++) begin
          r_delay[i] <= '0;
        end
      end else if (w_accept) begin
        r_delay[r_wr_ptr] <= in_data;
      end
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_data;
      end
    end
  end

  // Final MAC sum is captured straight from the adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_full  <= '0;
      r_out_sat   <= '0;
    end else begin
      r_out_valid <= w_last;
      if (w_last) begin
        r_out_full <= w_sum;
        r_out_sat  <= w_sat;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_full  = r_out_full;
  assign out_sat   = r_out_sat;

endmodule
